alu_arbiter: RTL

- Shares one `alu` instance between two requesters (port 0, port 1).
- Uses round-robin arbitration with valid/ready handshakes and a single registered response channel.
- Sits between the requesting control logic and the combinational `alu`.
- Serialises operations and holds each result stable until the consumer takes it.

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings, FSM state type and the op legality predicate
// for the two-port ALU arbiter.
package alu_arbiter_pkg;

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    function automatic logic alu_op_legal(input logic [2:0] op);
        return op <= ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both arbiter ports; illegal ops yield zero with err set.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             err
);

    always_comb begin
        c   = '0;
        err = !alu_op_legal(op);
        case (op)
            ALU_ADD: c = a + b;
            ALU_SUB: c = a - b;
            ALU_AND: c = a & b;
            ALU_OR:  c = a | b;
            ALU_SRL: c = a >> b[4:0];
            ALU_SRA: c = $signed(a) >>> b[4:0];
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a single registered response held until the consumer takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_c,
    output logic             resp_err,
    input  logic             resp_ready
);

    state_e           state;
    logic             last;
    logic             can_accept;
    logic             acc0;
    logic             acc1;
    logic             sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             alu_err;

    assign can_accept = !reset && ((state == StIdle) || resp_ready);

    // Each ready looks only at the other port's valid so it never depends on its own.
    assign req0_ready = can_accept && (!req1_valid || last);
    assign req1_ready = can_accept && (!req0_valid || !last);

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign sel  = acc1;

    assign alu_a  = sel ? req1_a  : req0_a;
    assign alu_b  = sel ? req1_b  : req0_b;
    assign alu_op = sel ? req1_op : req0_op;

    alu_arbiter_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .c  (alu_c),
        .err(alu_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            last       <= 1'b1;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_c     <= '0;
            resp_err   <= 1'b0;
        end else if (acc0 || acc1) begin
            state      <= StHold;
            last       <= sel;
            resp_valid <= 1'b1;
            resp_id    <= sel;
            resp_c     <= alu_c;
            resp_err   <= alu_err;
        end else if ((state == StHold) && resp_ready) begin
            state      <= StIdle;
            resp_valid <= 1'b0;
        end
    end

endmodule
